// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX engine among NUM_REQ byte sources,
// with bounded burst locking and a tx_done watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       err_timeout
);

    localparam int unsigned OwnerW = $clog2(NUM_REQ);
    localparam int unsigned BurstW = $clog2(MAX_BURST) + 1;
    localparam int unsigned WdW    = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StGrant, StStart, StWaitDone} state_e;

    state_e              state_q, state_d;
    logic [OwnerW-1:0]   owner_q, owner_d;
    logic [OwnerW-1:0]   rr_q, rr_d;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                tx_start_q;
    logic                busy_q;

    logic                pick_found;
    logic [OwnerW-1:0]   pick_idx;
    logic [OwnerW-1:0]   cand;
    logic [7:0]          src_byte [NUM_REQ];

    function automatic logic [OwnerW-1:0] next_idx(input logic [OwnerW-1:0] i);
        if (i == OwnerW'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + OwnerW'(1);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            src_byte[i] = req_data[8*i +: 8];
        end
    end

    // First valid source at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_q;
        cand       = rr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = OwnerW'((32'(rr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        burst_d     = burst_q;
        wd_d        = wd_q;
        tx_data_d   = tx_data_q;
        err_timeout = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    burst_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (req_valid[owner_q]) begin
                    tx_data_d = src_byte[owner_q];
                    state_d   = StStart;
                end else begin
                    rr_d    = next_idx(owner_q);
                    burst_d = '0;
                    state_d = StIdle;
                end
            end
            StStart: begin
                wd_d    = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                wd_d = wd_q + WdW'(1);
                // A tx_done coinciding with watchdog expiry takes priority.
                if (tx_done) begin
                    if (req_lock[owner_q] && req_valid[owner_q] &&
                        burst_q < BurstW'(MAX_BURST - 1)) begin
                        burst_d = burst_q + BurstW'(1);
                        state_d = StGrant;
                    end else begin
                        burst_d = '0;
                        rr_d    = next_idx(owner_q);
                        state_d = StIdle;
                    end
                end else if (wd_q == WdW'(TIMEOUT_CYC - 1)) begin
                    err_timeout = 1'b1;
                    burst_d     = '0;
                    rr_d        = next_idx(owner_q);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = '0;
        if (state_d == StGrant) begin
            req_ready_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            wd_q        <= '0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
            wd_q        <= wd_d;
            tx_data_q   <= tx_data_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= (state_d == StStart);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin/burst model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    logic [1:0]     owner;
    logic           err_timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] srcbuf [N][16];
    int         head [N];
    int         cnt [N];
    bit         lock_cfg [N];

    int         obs_src[$];
    logic [7:0] obs_dat[$];
    int         obs_gap[$];
    int         exp_src[$];
    logic [7:0] exp_dat[$];
    int         inv_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .MAX_BURST  (MB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .owner      (owner),
        .err_timeout(err_timeout)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1);
    end

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        tx_done   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            head[i]     = 0;
            cnt[i]      = 0;
            lock_cfg[i] = 1'b0;
        end
    endtask

    task automatic drive_from_queues();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (head[i] < cnt[i]);
            req_data[8*i +: 8] = (head[i] < cnt[i]) ? srcbuf[i][head[i]] : 8'h00;
            req_lock[i]        = lock_cfg[i];
        end
    endtask

    // Reference: walk the queued bytes with round-robin and bounded locked bursts.
    function automatic void build_expected();
        int h [N];
        int rr;
        int o;
        int b;
        int idx;
        bit left;
        exp_src.delete();
        exp_dat.delete();
        for (int i = 0; i < N; i++) h[i] = head[i];
        rr   = 0;
        left = 1'b1;
        while (left) begin
            left = 1'b0;
            for (int i = 0; i < N; i++) if (h[i] < cnt[i]) left = 1'b1;
            if (left) begin
                o = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (rr + k) % N;
                    if (o < 0 && h[idx] < cnt[idx]) o = idx;
                end
                exp_src.push_back(o);
                exp_dat.push_back(srcbuf[o][h[o]]);
                h[o]++;
                b = 0;
                while (lock_cfg[o] && h[o] < cnt[o] && b < MB - 1) begin
                    b++;
                    exp_src.push_back(o);
                    exp_dat.push_back(srcbuf[o][h[o]]);
                    h[o]++;
                end
                rr = (o + 1) % N;
            end
        end
    endfunction

    // Acts as byte sources and TX engine; records every tx_start and its distance from the
    // previous tx_done (in cycles).
    task automatic run_traffic(input int dmin, input int dmax, input int budget,
                               output bit timed_out);
        int       cd;
        int       last_done;
        bit       done;
        bit       empty;
        logic [N-1:0] rdy_prev;
        cd        = -1;
        last_done = -100;
        done      = 1'b0;
        rdy_prev  = '0;
        inv_err   = 0;
        obs_src.delete();
        obs_dat.delete();
        obs_gap.delete();
        drive_from_queues();
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            tx_done = 1'b0;
            if ($countones(req_ready) > 1 || (tx_start && req_ready != '0) || err_timeout)
                inv_err++;
            for (int i = 0; i < N; i++) begin
                if (rdy_prev[i] && head[i] < cnt[i]) head[i]++;
            end
            rdy_prev = req_ready;
            if (tx_start) begin
                obs_src.push_back(int'(owner));
                obs_dat.push_back(tx_data);
                obs_gap.push_back(c - last_done);
                cd = $urandom_range(dmax, dmin);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tx_done   = 1'b1;
                    cd        = -1;
                    last_done = c;
                end
            end
            drive_from_queues();
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (head[i] < cnt[i]) empty = 1'b0;
            if (cd < 0 && !tx_done && !busy && empty && rdy_prev == '0) done = 1'b1;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, tx_start, tx_data, busy, owner, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {req_ready, tx_start, tx_data, busy, owner, err_timeout});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_idle_hold: got busy=%0b ready=%b required 0/0000", busy,
                     req_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid          = 4'b0100;
        req_data[8*2 +: 8] = 8'hA5;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || owner !== 2'd2 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got ready=%b owner=%0d start=%0b required 0100/2/0",
                     req_ready, owner, tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || req_ready !== '0) begin
            errors++;
            $display("FAIL single_start: got start=%0b data=%0h ready=%b required 1/a5/0000",
                     tx_start, tx_data, req_ready);
        end
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'hA5 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got busy=%0b data=%0h required 0/a5", busy, tx_data);
        end
    endtask

    task automatic test_fairness();
        bit to;
        int ord [5] = '{0, 1, 2, 3, 0};
        int used [N];
        do_reset();
        clear_queues();
        for (int i = 0; i < N; i++) begin
            cnt[i]       = 1;
            used[i]      = 0;
            srcbuf[i][0] = 8'($urandom);
        end
        cnt[0]       = 2;
        srcbuf[0][1] = 8'($urandom);
        run_traffic(10, 10, 2000, to);
        checks++;
        if (to || obs_src.size() != 5) begin
            errors++;
            $display("FAIL fair_count: got %0d bytes timed_out=%0b required 5/0",
                     obs_src.size(), to);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs_src[k] != ord[k] || obs_dat[k] !== srcbuf[ord[k]][used[ord[k]]]) begin
                    errors++;
                    $display("FAIL fair_order[%0d]: got src%0d/%0h required src%0d/%0h", k,
                             obs_src[k], obs_dat[k], ord[k], srcbuf[ord[k]][used[ord[k]]]);
                end
                used[ord[k]]++;
            end
        end
    endtask

    task automatic test_burst();
        bit to;
        int ord [7] = '{1, 1, 1, 1, 3, 1, 1};
        int gap [5] = '{0, 2, 2, 2, 3};
        do_reset();
        clear_queues();
        cnt[1]      = 6;
        lock_cfg[1] = 1'b1;
        cnt[3]      = 1;
        for (int j = 0; j < 6; j++) srcbuf[1][j] = 8'(8'h10 + j);
        srcbuf[3][0] = 8'h33;
        run_traffic(2, 5, 2000, to);
        checks++;
        if (to || obs_src.size() != 7) begin
            errors++;
            $display("FAIL burst_count: got %0d bytes timed_out=%0b required 7/0",
                     obs_src.size(), to);
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (obs_src[k] != ord[k]) begin
                    errors++;
                    $display("FAIL burst_order[%0d]: got src%0d required src%0d", k,
                             obs_src[k], ord[k]);
                end
            end
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (obs_gap[k] != gap[k]) begin
                    errors++;
                    $display("FAIL burst_latency[%0d]: got %0d cycles required %0d", k,
                             obs_gap[k], gap[k]);
                end
            end
            checks++;
            if (obs_dat[3] !== 8'h13 || obs_dat[4] !== 8'h33) begin
                errors++;
                $display("FAIL burst_data: got %0h/%0h required 13/33", obs_dat[3],
                         obs_dat[4]);
            end
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int k;
        do_reset();
        req_valid          = 4'b0100;
        req_data[8*2 +: 8] = 8'h5A;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        req_valid = '0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_start: got no tx_start required tx_start within 10 cycles");
        end
        k    = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            k++;
            if (err_timeout) seen = 1'b1;
        end
        checks++;
        if (!seen || k != TO) begin
            errors++;
            $display("FAIL timeout_delay: got seen=%0b after %0d cycles required 1/%0d",
                     seen, k, TO);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got err=%0b busy=%0b required 0/0", err_timeout,
                     busy);
        end
        req_valid = 4'b1100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL timeout_rr_advance: got ready=%b owner=%0d required 1000/3",
                     req_ready, owner);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        do_reset();
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL withdraw_grant: got ready=%b required 0001", req_ready);
        end
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL withdraw_idle: got busy=%0b start=%0b ready=%b required 0/0/0000",
                     busy, tx_start, req_ready);
        end
        req_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (owner !== 2'd1 || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL withdraw_next_owner: got owner=%0d ready=%b required 1/0010",
                     owner, req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_second: got busy=%0b start=%0b required 0/0", busy,
                     tx_start);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        req_valid          = 4'b1000;
        req_data[8*3 +: 8] = 8'h3C;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (!seen || busy !== 1'b1 || owner !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_setup: got seen=%0b busy=%0b owner=%0d required 1/1/3",
                     seen, busy, owner);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_data: got ready=%b start=%0b data=%0h required 0/0/0",
                     req_ready, tx_start, tx_data);
        end
        checks++;
        if (busy !== 1'b0 || owner !== 2'd0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got busy=%0b owner=%0d err=%0b required 0/0/0",
                     busy, owner, err_timeout);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (tx_start !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL stray_done[%0d]: got start=%0b busy=%0b required 0/0", c,
                         tx_start, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        bit to;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            clear_queues();
            for (int i = 0; i < N; i++) begin
                cnt[i]      = $urandom_range(6, 0);
                lock_cfg[i] = 1'($urandom_range(1, 0));
                for (int j = 0; j < 16; j++) srcbuf[i][j] = 8'($urandom);
            end
            build_expected();
            run_traffic(1, 8, 4000, to);
            checks++;
            if (to || inv_err != 0 || obs_src.size() != exp_src.size()) begin
                errors++;
                $display("FAIL rand[%0d]_summary: got n=%0d to=%0b inv=%0d required n=%0d 0 0",
                         r, obs_src.size(), to, inv_err, exp_src.size());
            end else begin
                for (int k = 0; k < exp_src.size(); k++) begin
                    checks++;
                    if (obs_src[k] != exp_src[k] || obs_dat[k] !== exp_dat[k]) begin
                        errors++;
                        $display("FAIL rand[%0d]_byte[%0d]: got src%0d/%0h required src%0d/%0h",
                                 r, k, obs_src[k], obs_dat[k], exp_src[k], exp_dat[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        clear_queues();
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
